// File: rtl/debug_mem_loader.sv
// Front-panel program loader: debounced push-button commands become single-cycle
// writes on the instruction/data memory debug ports, and the CPU is held in reset until RELEASE.
module debug_mem_loader #(
  parameter int DATA_W          = 8,
  parameter int INST_W          = 16,
  parameter int I_ADDR_W        = 12,
  parameter int D_ADDR_W        = 12,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_raw,
  input  logic [1:0]          cmd_in,
  input  logic [INST_W-1:0]   data_in,
  output logic                imem_debug_we,
  output logic [I_ADDR_W-1:0] imem_debug_waddr,
  output logic [INST_W-1:0]   imem_debug_wdata,
  output logic                dmem_debug_we,
  output logic [D_ADDR_W-1:0] dmem_debug_waddr,
  output logic [DATA_W-1:0]   dmem_debug_wdata,
  output logic [I_ADDR_W-1:0] addr_ptr,
  output logic [15:0]         write_count,
  output logic                cpu_hold
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] CMD_SET_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_IMEM  = 2'b01;
  localparam logic [1:0] CMD_WR_DMEM  = 2'b10;
  localparam logic [1:0] CMD_RELEASE  = 2'b11;

  generate
    if (D_ADDR_W > I_ADDR_W) begin : g_bad_daddr
      $error("debug_mem_loader: D_ADDR_W must not exceed I_ADDR_W");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("debug_mem_loader: DEBOUNCE_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_LOW} state_t;

  state_t              state, next_state;
  logic                sync1, sync2, db_level;
  logic [CNT_W-1:0]    db_cnt;
  logic [1:0]          cmd_q;
  logic [I_ADDR_W-1:0] set_addr_q;
  logic                accept;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // IDLE is only ever entered with the debounced level low, so a high level here is a fresh rise.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (db_level) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC:     next_state = WAIT_LOW;
      WAIT_LOW: if (!db_level) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Strobe and cpu_hold are launched on acceptance so they are visible during EXEC;
  // pointer and count advance at the end of EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_debug_we    <= 1'b0;
      imem_debug_waddr <= '0;
      imem_debug_wdata <= '0;
      dmem_debug_we    <= 1'b0;
      dmem_debug_waddr <= '0;
      dmem_debug_wdata <= '0;
      addr_ptr         <= '0;
      write_count      <= '0;
      cpu_hold         <= 1'b1;
      cmd_q            <= CMD_SET_ADDR;
      set_addr_q       <= '0;
    end else begin
      imem_debug_we <= 1'b0;
      dmem_debug_we <= 1'b0;
      if (accept) begin
        cmd_q      <= cmd_in;
        set_addr_q <= data_in[I_ADDR_W-1:0];
        case (cmd_in)
          CMD_WR_IMEM: begin
            imem_debug_we    <= 1'b1;
            imem_debug_waddr <= addr_ptr;
            imem_debug_wdata <= data_in;
            cpu_hold         <= 1'b1;
          end
          CMD_WR_DMEM: begin
            dmem_debug_we    <= 1'b1;
            dmem_debug_waddr <= addr_ptr[D_ADDR_W-1:0];
            dmem_debug_wdata <= data_in[DATA_W-1:0];
            cpu_hold         <= 1'b1;
          end
          CMD_RELEASE: cpu_hold <= 1'b0;
          default:     cpu_hold <= 1'b1;
        endcase
      end
      if (state == EXEC) begin
        case (cmd_q)
          CMD_SET_ADDR: addr_ptr <= set_addr_q;
          CMD_WR_IMEM, CMD_WR_DMEM: begin
            addr_ptr <= addr_ptr + I_ADDR_W'(1);
            if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_mem_loader.sv
// Bench for debug_mem_loader: directed table, hand-written timing/reset/glitch
// sequences and randomized commands against a behavioural loader model.
module tb_debug_mem_loader;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_raw;
  logic [1:0]  cmd_in;
  logic [15:0] data_in;
  logic        imem_we, dmem_we, cpu_hold;
  logic [11:0] imem_waddr, dmem_waddr, addr_ptr;
  logic [15:0] imem_wdata, write_count;
  logic [7:0]  dmem_wdata;

  int checks   = 0;
  int failures = 0;

  // Expected write: {is_dmem, addr[11:0], data[15:0]}
  logic [28:0] exp_q[$];

  logic [11:0] m_ptr;
  logic [15:0] m_cnt;
  logic        m_hold;

  debug_mem_loader #(
    .DATA_W(8), .INST_W(16), .I_ADDR_W(12), .D_ADDR_W(12), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(rst), .btn_raw(btn_raw), .cmd_in(cmd_in), .data_in(data_in),
    .imem_debug_we(imem_we), .imem_debug_waddr(imem_waddr), .imem_debug_wdata(imem_wdata),
    .dmem_debug_we(dmem_we), .dmem_debug_waddr(dmem_waddr), .dmem_debug_wdata(dmem_wdata),
    .addr_ptr(addr_ptr), .write_count(write_count), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!rst && (imem_we || dmem_we)) begin
      logic [28:0] got;
      checks++;
      if (imem_we && dmem_we) begin
        failures++;
        $display("FAIL we_exclusive actual=both_high expected=one_high");
      end
      got = imem_we ? {1'b0, imem_waddr, imem_wdata} : {1'b1, dmem_waddr, 8'h00, dmem_wdata};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual=%0h expected=none", got);
      end else begin
        logic [28:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL strobe_payload actual=%0h expected=%0h", got, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_ptr  = 12'h000;
    m_cnt  = 16'h0000;
    m_hold = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [1:0] c, input logic [15:0] d);
    case (c)
      2'b00: begin m_ptr = d[11:0]; m_hold = 1'b1; end
      2'b11: m_hold = 1'b0;
      default: begin
        if (c == 2'b01) exp_q.push_back({1'b0, m_ptr, d});
        else            exp_q.push_back({1'b1, m_ptr, 8'h00, d[7:0]});
        m_ptr  = m_ptr + 12'd1;
        m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        m_hold = 1'b1;
      end
    endcase
  endtask

  task automatic press(input logic [1:0] c, input logic [15:0] d, input int hold, input int gap);
    @(negedge clk);
    cmd_in  = c;
    data_in = d;
    btn_raw = 1'b1;
    repeat (hold) @(negedge clk);
    btn_raw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ptr"}, addr_ptr, m_ptr);
    check({tag, "_count"}, write_count, m_cnt);
    check({tag, "_hold"}, cpu_hold, m_hold);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] data;
    int          hold;
    logic [1:0]  exp_we;   // bit0 imem, bit1 dmem
    logic [11:0] exp_waddr;
    logic [15:0] exp_wdata;
    logic [11:0] exp_ptr;
    logic [15:0] exp_cnt;
    logic        exp_hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    int found;
    logic prev_hold;
    logic [11:0] old_ptr;

    tbl[0] = '{2'b00, 16'h0010, 10, 2'b00, 12'h000, 16'h0000, 12'h010, 16'd0, 1'b1};
    tbl[1] = '{2'b01, 16'hA5C3, 50, 2'b01, 12'h010, 16'hA5C3, 12'h011, 16'd1, 1'b1};
    tbl[2] = '{2'b00, 16'h0FFF,  8, 2'b00, 12'h000, 16'h0000, 12'hFFF, 16'd1, 1'b1};
    tbl[3] = '{2'b10, 16'h12EE,  8, 2'b10, 12'hFFF, 16'h00EE, 12'h000, 16'd2, 1'b1};
    tbl[4] = '{2'b11, 16'h7777,  8, 2'b00, 12'h000, 16'h0000, 12'h000, 16'd2, 1'b0};
    tbl[5] = '{2'b01, 16'h1234,  8, 2'b01, 12'h000, 16'h1234, 12'h001, 16'd3, 1'b1};
    tbl[6] = '{2'b00, 16'hF123,  6, 2'b00, 12'h000, 16'h0000, 12'h123, 16'd3, 1'b1};

    rst = 1'b1; btn_raw = 1'b0; cmd_in = 2'b00; data_in = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_imem_we", imem_we, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_ptr", addr_ptr, 12'h000);
    check("rst_count", write_count, 16'h0000);
    check("rst_hold", cpu_hold, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].exp_we[0]) exp_q.push_back({1'b0, tbl[i].exp_waddr, tbl[i].exp_wdata});
      if (tbl[i].exp_we[1]) exp_q.push_back({1'b1, tbl[i].exp_waddr, tbl[i].exp_wdata});
      press(tbl[i].cmd, tbl[i].data, tbl[i].hold, 12);
      check($sformatf("tbl%0d_ptr", i), addr_ptr, tbl[i].exp_ptr);
      check($sformatf("tbl%0d_count", i), write_count, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_hold", i), cpu_hold, tbl[i].exp_hold);
      check($sformatf("tbl%0d_pending", i), exp_q.size(), 0);
    end
    m_ptr = tbl[6].exp_ptr; m_cnt = tbl[6].exp_cnt; m_hold = tbl[6].exp_hold;

    // Latency: strobe DB+3 cycles after the press; cpu_hold rises with it; pointer moves one cycle later
    model_apply(2'b11, 16'h0000);
    press(2'b11, 16'h0000, 8, 12);
    check_model("release");
    old_ptr = m_ptr;
    model_apply(2'b01, 16'hBEEF);
    @(negedge clk);
    cmd_in = 2'b01; data_in = 16'hBEEF; btn_raw = 1'b1;
    found = 0; prev_hold = cpu_hold;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (imem_we) begin found = 1; break; end
      prev_hold = cpu_hold;
    end
    check("lat_strobe_seen", found, 1);
    check("lat_cycles", n, DB + 3);
    check("lat_hold_before", prev_hold, 1'b0);
    check("lat_hold_with_strobe", cpu_hold, 1'b1);
    check("lat_ptr_during", addr_ptr, old_ptr);
    @(negedge clk);
    check("lat_ptr_after", addr_ptr, m_ptr);
    check("lat_we_one_cycle", imem_we, 1'b0);
    repeat (48) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_model("lat");

    // Short glitches never fire a command; a 6-cycle press fires exactly one
    cmd_in = 2'b01; data_in = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      btn_raw = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      btn_raw = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_model("glitch_high");
    model_apply(2'b10, 16'h5A3C);
    press(2'b10, 16'h5A3C, 6, 12);
    check_model("press6");
    // Brief low dropout while held does not retrigger
    model_apply(2'b01, 16'h0F0F);
    @(negedge clk);
    cmd_in = 2'b01; data_in = 16'h0F0F; btn_raw = 1'b1;
    repeat (10) @(negedge clk);
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    btn_raw = 1'b1;
    repeat (20) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_model("glitch_low");

    // Reset during EXEC of WR_IMEM, button kept held across reset
    model_apply(2'b01, 16'hC0DE);
    @(negedge clk);
    cmd_in = 2'b01; data_in = 16'hC0DE; btn_raw = 1'b1;
    found = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (imem_we) begin found = 1; break; end
    end
    check("exec_rst_strobe_seen", found, 1);
    #2 rst = 1'b1;
    #1;
    check("exec_rst_we", imem_we, 1'b0);
    check("exec_rst_hold", cpu_hold, 1'b1);
    check("exec_rst_ptr", addr_ptr, 12'h000);
    check("exec_rst_count", write_count, 16'h0000);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_apply(2'b01, 16'hC0DE);
    found = 0;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin found = 1; break; end
    end
    check("held_reset_fire", found, 1);
    repeat (5) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    check_model("held_reset");

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  c;
      logic [15:0] d;
      c = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      if (c == 2'b00 && $urandom_range(0, 1) == 1) d[11:0] = 12'hFF0 | 12'($urandom_range(0, 15));
      model_apply(c, d);
      press(c, d, $urandom_range(6, 20), $urandom_range(10, 14));
      check_model($sformatf("rnd%0d", i));
    end

    check("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_mem_loader.md
Name: debug_mem_loader

Overview:
- Front-panel program loader: turns switch value + push-button commands into write transactions on the CPU subsystem's instruction- and data-memory debug write ports.
- The write-direction counterpart of the existing debug read path (debug_enable/addr/rdata).
- Sits in the FPGA wrapper between the board I/O and turtle_cpu_subsystem.
- Holds the CPU in reset via cpu_hold until a RELEASE command.

Parameters:
DATA_W, 8, data memory word width
INST_W, 16, instruction width; also width of data_in
I_ADDR_W, 12, instruction address width; also width of the address pointer
D_ADDR_W, 12, data address width; must be <= I_ADDR_W (elaboration-time assertion)
DEBOUNCE_CYCLES, 1000000, consecutive stable samples before a button level is accepted (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_raw  input  1  unsynchronized push button
cmd_in  input  2  command select: 00 SET_ADDR, 01 WR_IMEM, 10 WR_DMEM, 11 RELEASE
data_in  input  INST_W  switch value (address or write data)
imem_debug_we  output  1  one-cycle instruction memory write strobe
imem_debug_waddr  output  I_ADDR_W  instruction memory write address
imem_debug_wdata  output  INST_W  instruction memory write data
dmem_debug_we  output  1  one-cycle data memory write strobe
dmem_debug_waddr  output  D_ADDR_W  data memory write address
dmem_debug_wdata  output  DATA_W  data memory write data
addr_ptr  output  I_ADDR_W  current load pointer, for display
write_count  output  16  saturating count of completed writes
cpu_hold  output  1  1 = hold CPU core in reset

Behaviour:
Reset (asynchronous, active-high):
- All outputs 0 except cpu_hold = 1.
- Synchronizer, debounce counter and FSM are cleared; debounced level = 0.

Input conditioning:
- btn_raw passes through a 2-flop synchronizer.
- Debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any sample equal to the current debounced level clears the counter.
- cmd_in and data_in are quasi-static: sampled only in the cycle the command is accepted, never synchronized.

FSM states:
- IDLE: on a debounced 0->1 transition, capture cmd_in/data_in into registers and go to EXEC.
- EXEC (exactly 1 cycle): perform the captured command, then go to WAIT_LOW.
- WAIT_LOW: stay while the debounced level is 1; return to IDLE when it is 0.
- Exactly one command per press, however long the button is held.

Commands (executed in EXEC; all outputs registered):
- SET_ADDR: addr_ptr <= data_in[I_ADDR_W-1:0]; no strobe.
- WR_IMEM:
  - imem_debug_we = 1 for one cycle, with imem_debug_waddr = addr_ptr and imem_debug_wdata = captured data_in.
  - addr_ptr increments, wrapping 2^I_ADDR_W-1 -> 0.
  - write_count increments.
  - cpu_hold <= 1.
- WR_DMEM:
  - dmem_debug_we = 1 for one cycle, with dmem_debug_waddr = addr_ptr[D_ADDR_W-1:0] and dmem_debug_wdata = data_in[DATA_W-1:0].
  - addr_ptr and write_count behave as for WR_IMEM; cpu_hold <= 1.
- RELEASE: cpu_hold <= 0; addr_ptr and write_count unchanged.
- SET_ADDR also sets cpu_hold <= 1, so any load command re-halts the CPU.

Timing and output rules:
- Latency: strobe is high in the cycle after the debounced rise is detected; addr_ptr shows the incremented value in the cycle after the strobe.
- waddr/wdata are valid whenever the corresponding we is high; they may hold stale values otherwise.
- imem_debug_we and dmem_debug_we are never high together.
- write_count saturates at 16'hFFFF.

Boundary cases:
- Reset asserted mid-EXEC: the strobe drops immediately.
- Button still held when reset releases: the debounced level must first reach 1 from 0, so one command fires after DEBOUNCE_CYCLES.
- Glitch shorter than DEBOUNCE_CYCLES, in either direction: ignored.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, cmd=00, data=16'h0010, press 10 cycles -> addr_ptr=0x010, no strobe, cpu_hold=1.
- cmd=01, data=16'hA5C3, press -> exactly one imem_debug_we pulse with waddr=0x010 and wdata=16'hA5C3; addr_ptr=0x011; write_count=1. Holding the button 50 cycles produces no second pulse.
- SET_ADDR 0xFFF, then WR_DMEM data=16'h12EE -> dmem_debug_we with waddr=0xFFF and wdata=8'hEE; addr_ptr wraps to 0x000.
- btn_raw pulses of 1-3 cycles, repeated -> no command executed, FSM stays in IDLE; a 6-cycle press executes exactly one command.
- cmd=11, press -> cpu_hold falls to 0 and no strobe fires. A following WR_IMEM re-asserts cpu_hold = 1 in the same cycle as its strobe.
- Reset asserted in the EXEC cycle of WR_IMEM -> we=0 and cpu_hold=1 immediately, addr_ptr=0, write_count=0.
